// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer and its benches.
// Holds the sweep state encoding, default parameter values and the expected
// truth table of the exp_4 expression (s = a & ~(b & c)).
package tt_seq_pkg;

  // Default number of driven inputs; vector code is {a,b,c} with a as MSB.
  localparam int unsigned DEF_N_IN   = 3;
  // Default number of cycles each vector is held before it is sampled.
  localparam int unsigned DEF_SETTLE = 1;
  // Expected output of exp_4 per code: codes 4, 5 and 6 give 1.
  localparam logic [7:0]  EXP4_TRUTH = 8'h70;

  // Sweep states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Start/status and stimulus/response bundle of the truth-table sequencer.
// The master side is the sequencer itself; the slave side is whatever issues
// start, reads the results and hosts the combinational block under test.
interface truth_table_sequencer_if
  import tt_seq_pkg::*;
#(
  parameter int unsigned N_IN = DEF_N_IN
);

  logic            start;       // request a sweep (honoured only in IDLE)
  logic [N_IN-1:0] vec;         // vector applied to the block under test
  logic            dut_s;       // response of the block under test
  logic            busy;        // sweep in progress
  logic            done;        // one-cycle completion pulse
  logic            pass;        // last completed sweep had no mismatch
  logic [N_IN:0]   err_count;   // mismatches in the last sweep
  logic            fail_valid;  // at least one mismatch recorded
  logic [N_IN-1:0] fail_code;   // code of the first mismatch

  modport master (
    input  start,
    input  dut_s,
    output vec,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_code
  );

  modport slave (
    output start,
    output dut_s,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_code
  );

endinterface

// File: rtl/truth_table_sequencer.sv
// Clocked, self-checking sweep of a small combinational block.
// Every input code 0..2^N_IN-1 is driven on vec, held SETTLE cycles plus one
// sample cycle, and the response is compared against EXPECT[code]. The
// mismatch count, first failing code and pass flag hold until the next start.
// Optional build macro: STOP_ON_FAIL_EN -- the first mismatch ends the sweep.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int unsigned              N_IN   = DEF_N_IN,
  parameter int unsigned              SETTLE = DEF_SETTLE,  // legal 1..15
  parameter logic [(1<<N_IN)-1:0]     EXPECT = EXP4_TRUTH
) (
  input  logic                     clk,
  input  logic                     reset,
  truth_table_sequencer_if.master  bus
);

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] CODE_LAST   = {N_IN{1'b1}};

  tt_state_e       state_q;
  logic [N_IN-1:0] code_q;
  logic [3:0]      wait_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_code_q;

  logic            mismatch;
  logic [N_IN:0]   err_d;
  logic            end_sweep;

  // Compare the sampled response and work out whether this sample ends the sweep.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    mismatch  = 1'b0;
    err_d     = err_q;
    end_sweep = 1'b0;
    mismatch  = (bus.dut_s != EXPECT[code_q]);
    err_d     = err_q + {{N_IN{1'b0}}, mismatch};
`ifdef STOP_ON_FAIL_EN
    end_sweep = (code_q == CODE_LAST) || mismatch;
`else
    end_sweep = (code_q == CODE_LAST);
`endif
  end

  // Sweep FSM with registered vector and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    if (reset) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      wait_q       <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_code_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            code_q       <= '0;
            wait_q       <= '0;
            vec_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_code_q  <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (wait_q == SETTLE_LAST) begin
            state_q <= ST_SAMPLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_code_q  <= code_q;
            fail_valid_q <= 1'b1;
          end
          if (end_sweep) begin
            // The final sample is already folded into err_d.
            pass_q  <= (err_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            code_q  <= code_q + 1'b1;
            vec_q   <= code_q + 1'b1;
            wait_q  <= '0;
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // start is deliberately ignored here; results are already final.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_code  = fail_code_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a default instance (SETTLE=1) and a
// SETTLE=3 instance whose response glitches early in every vector window.
// The block under test is modelled as a lookup table driven from vec.
module tb_truth_table_sequencer;
  import tt_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sequencer_if #(.N_IN(3)) if1 ();
  truth_table_sequencer_if #(.N_IN(3)) if3 ();

  logic [7:0] tbl1;
  logic [7:0] tbl3;
  logic       glitch_en;
  logic       glitch_val;

  assign if1.dut_s = tbl1[if1.vec];
  assign if3.dut_s = glitch_en ? glitch_val : tbl3[if3.vec];

  truth_table_sequencer u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );

  truth_table_sequencer #(.SETTLE(3)) u3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.master)
  );

  // Observation mux: sel=0 watches u1, sel=1 watches u3.
  logic       sel;
  logic [2:0] o_vec;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [3:0] o_err;
  logic [2:0] o_fc;
  assign o_vec  = sel ? if3.vec        : if1.vec;
  assign o_busy = sel ? if3.busy       : if1.busy;
  assign o_done = sel ? if3.done       : if1.done;
  assign o_pass = sel ? if3.pass       : if1.pass;
  assign o_fv   = sel ? if3.fail_valid : if1.fail_valid;
  assign o_err  = sel ? if3.err_count  : if1.err_count;
  assign o_fc   = sel ? if3.fail_code  : if1.fail_code;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what a sweep must report for a block whose truth table is tbl.
  task automatic model(input logic [7:0] tbl, input int s,
                       output int errs, output int ff, output int lat, output int vfin);
    logic [7:0] diff;
    diff = tbl ^ EXP4_TRUTH;
    errs = $countones(diff);
    ff   = -1;
    for (int i = 7; i >= 0; i--) if (diff[i]) ff = i;
    lat  = 8 * (s + 1);
    vfin = 7;
`ifdef STOP_ON_FAIL_EN
    if (ff >= 0) begin
      errs = 1;
      lat  = (ff + 1) * (s + 1);
      vfin = ff;
    end
`endif
  endtask

  task automatic set_start(input logic which, input logic v);
    if (which) if3.start = v;
    else       if1.start = v;
  endtask

  // One sweep; restart_at = cycle index whose edge sees a second start (-1: none).
  task automatic do_sweep(input logic which, input logic [7:0] tbl, input int restart_at);
    int errs, ff, lat, vfin, s;
    s = which ? 3 : 1;
    model(tbl, s, errs, ff, lat, vfin);
    sel = which;
    if (which) tbl3 = tbl;
    else       tbl1 = tbl;
    @(negedge clk);
    set_start(which, 1'b1);
    for (int k = 0; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      set_start(which, restart_at == k + 1);
      glitch_en  = which && (k < lat) && ((k % (s + 1)) < 2);
      glitch_val = 1'($urandom);
      @(negedge clk);
      check($sformatf("vec[t%0h k%0d]", tbl, k), o_vec, (k < lat) ? k / (s + 1) : vfin);
      check($sformatf("busy[t%0h k%0d]", tbl, k), o_busy, k < lat);
      check($sformatf("done[t%0h k%0d]", tbl, k), o_done, k == lat);
      if (k >= lat) begin
        check($sformatf("err[t%0h]", tbl), o_err, errs);
        check($sformatf("pass[t%0h]", tbl), o_pass, errs == 0);
        check($sformatf("fail_valid[t%0h]", tbl), o_fv, ff >= 0);
        check($sformatf("fail_code[t%0h]", tbl), o_fc, (ff >= 0) ? ff : 0);
      end
    end
    glitch_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if1.start = 1'b0;
    if3.start = 1'b0;
    tbl1 = EXP4_TRUTH;
    tbl3 = EXP4_TRUTH;
    glitch_en = 1'b0;
    glitch_val = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst u1 outputs", {if1.vec, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_valid, if1.fail_code}, 0);
    check("rst u3 outputs", {if3.vec, if3.busy, if3.done, if3.pass, if3.err_count, if3.fail_valid, if3.fail_code}, 0);

    // Correct block, stuck-at-0 block, inverted block.
    do_sweep(1'b0, EXP4_TRUTH, -1);
    do_sweep(1'b0, 8'h00, -1);
    do_sweep(1'b0, ~EXP4_TRUTH, -1);
    // SETTLE=3 with early-window glitches.
    do_sweep(1'b1, EXP4_TRUTH, -1);
    // start re-asserted mid-sweep is ignored.
    do_sweep(1'b0, EXP4_TRUTH, 5);

    // Reset sampled at cycle 7 of a failing sweep.
    sel  = 1'b0;
    tbl1 = ~EXP4_TRUTH;
    @(negedge clk);
    if1.start = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1 if1.start = 1'b0;
      if (k == 6) reset = 1'b1;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst busy", if1.busy, 0);
    check("midrst vec", if1.vec, 0);
    check("midrst done", if1.done, 0);
    check("midrst err", if1.err_count, 0);
    check("midrst fail_valid", if1.fail_valid, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("midrst quiet k%0d", k), {if1.busy, if1.done}, 0);
    end
    do_sweep(1'b0, EXP4_TRUTH, -1);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset = 1'b1;
    if1.start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    if1.start = 1'b0;
    @(negedge clk);
    check("rst_prio busy", if1.busy, 0);
    @(negedge clk);
    check("rst_prio idle", {if1.busy, if1.done, if1.vec}, 0);

    // Randomized blocks on either instance.
    for (int r = 0; r < 6; r++) begin
      logic       w;
      logic [7:0] t;
      w = 1'($urandom_range(0, 1));
      t = 8'($urandom);
      do_sweep(w, t, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
